// File: rtl/regdump_injector_pkg.sv
// Shared definitions for the register-dump sequencer: FSM state encoding and
// the instruction field layout used to build the injected probe.
package regdump_injector_pkg;

  // Sequencer states, 3-bit encoding shared with the pipeline-side decoder.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INJECT = 3'd1,
    ST_SETTLE = 3'd2,
    ST_EMIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // ADDI opcode; with rt=$0 and imm=0 the probe reads rs and writes nothing.
  localparam logic [5:0] ADDI_OP = 6'b001000;

  // Opcode occupies the top OP_W bits; rs follows directly below it.
  localparam int OP_W = 6;

endpackage

// File: rtl/regdump_injector_mux_32.sv
// 32-bit two-way select between the fetched instruction and the probe.
module mux_32 (
  input  logic        sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/regdump_injector.sv
// Debug sequencer: overrides the fetch stream with ADDI $0,$idx,0 probes,
// captures each register from busA once it has settled, and streams
// {index, value} beats out over a valid/ready port.
module regdump_injector
  import regdump_injector_pkg::*;
#(
  parameter int         DATA_W        = 32,
  parameter int         NUM_REGS      = 32,
  parameter int         IDX_W         = 5,
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [5:0] PROBE_OP      = ADDI_OP
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  first_reg,
  input  logic [IDX_W-1:0]  last_reg,
  input  logic [DATA_W-1:0] inst_in,
  output logic [DATA_W-1:0] inst_out,
  output logic              override,
  input  logic [DATA_W-1:0] busA_probe,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [IDX_W-1:0]  dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done
);

  localparam int               CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int               NUM_MUX = DATA_W / 32;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_REGS - 1);

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [IDX_W-1:0]    end_reg, end_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                dump_valid_reg, dump_valid_next;
  logic [IDX_W-1:0]    dump_idx_reg, dump_idx_next;
  logic [DATA_W-1:0]   dump_data_reg, dump_data_next;
  logic [DATA_W-1:0]   probe_inst;

  // State and capture registers; reset abandons any dump in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      end_reg        <= '0;
      cnt_reg        <= '0;
      dump_valid_reg <= 1'b0;
      dump_idx_reg   <= '0;
      dump_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      end_reg        <= end_next;
      cnt_reg        <= cnt_next;
      dump_valid_reg <= dump_valid_next;
      dump_idx_reg   <= dump_idx_next;
      dump_data_reg  <= dump_data_next;
    end
  end

  // Next-state logic: inject, wait for busA to settle, emit, advance or finish.
  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    end_next        = end_reg;
    cnt_next        = cnt_reg;
    dump_valid_next = dump_valid_reg;
    dump_idx_next   = dump_idx_reg;
    dump_data_next  = dump_data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          idx_next   = first_reg;
          end_next   = last_reg;
          state_next = ST_INJECT;
        end
      end
      ST_INJECT: begin
        cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
        state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_reg == '0) begin
          dump_data_next  = busA_probe;
          dump_idx_next   = idx_reg;
          dump_valid_next = 1'b1;
          state_next      = ST_EMIT;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_EMIT: begin
        if (dump_valid_reg && dump_ready) begin
          dump_valid_next = 1'b0;
          if (idx_reg == end_reg) begin
            state_next = ST_DONE;
          end else begin
            // Range may wrap past the top register back to $0.
            idx_next   = (idx_reg == IDX_MAX) ? '0 : idx_reg + 1'b1;
            state_next = ST_INJECT;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Probe instruction: opcode, rs=idx, rt=$0, all lower bits zero.
  always_comb begin
    probe_inst                            = '0;
    probe_inst[DATA_W-1 -: OP_W]          = PROBE_OP;
    probe_inst[DATA_W-OP_W-1 -: IDX_W]    = idx_reg;
  end

  // Probe stays on the bus through EMIT so real code is not fetched mid-dump.
  assign override   = (state_reg == ST_INJECT) || (state_reg == ST_SETTLE) ||
                      (state_reg == ST_EMIT);
  assign busy       = (state_reg != ST_IDLE);
  assign done       = (state_reg == ST_DONE);
  assign dump_valid = dump_valid_reg;
  assign dump_idx   = dump_idx_reg;
  assign dump_data  = dump_data_reg;

  // One 32-bit select per word of the instruction bus.
  generate
    for (genvar gi = 0; gi < NUM_MUX; gi++) begin : g_inst_mux
      mux_32 u_mux (
        .sel (override),
        .a   (inst_in[gi*32 +: 32]),
        .b   (probe_inst[gi*32 +: 32]),
        .y   (inst_out[gi*32 +: 32])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regdump_injector.sv
// Bench for regdump_injector: a small pipeline model feeds busA from a
// register file, and every accepted beat is compared against the range the
// dump was asked for.
module tb_regdump_injector;

  localparam int NUM_REGS = 32;
  localparam int SETTLE   = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [4:0]  first_reg, last_reg;
  logic [31:0] inst_in, inst_out, busA_probe, dump_data;
  logic        override, dump_valid, dump_ready, busy, done;
  logic [4:0]  dump_idx;

  always #5 clk = ~clk;

  regdump_injector dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .first_reg  (first_reg),
    .last_reg   (last_reg),
    .inst_in    (inst_in),
    .inst_out   (inst_out),
    .override   (override),
    .busA_probe (busA_probe),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .busy       (busy),
    .done       (done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pipeline model: fetch latch, then registered rs read onto busA; ADDI
  // with nonzero rt writes back, so a bad probe would corrupt registers.
  logic [31:0] regs    [NUM_REGS];
  logic [31:0] pattern [NUM_REGS];
  logic        load;
  logic [31:0] fetch_q;

  always @(posedge clk) begin
    if (load) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= (r == 0) ? 32'd0 : pattern[r];
      fetch_q    <= '0;
      busA_probe <= '0;
    end else begin
      fetch_q    <= inst_out;
      busA_probe <= regs[fetch_q[25:21]];
      if (fetch_q[31:26] == 6'b001000 && fetch_q[20:16] != 5'd0)
        regs[fetch_q[20:16]] <= regs[fetch_q[25:21]] + {{16{fetch_q[15]}}, fetch_q[15:0]};
    end
  end

  // Consumer: 0 = always ready, 1 = random, 2 = low for 10 valid cycles.
  int rdy_mode   = 0;
  int stall_left = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: dump_ready = 1'b1;
      1: dump_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (stall_left > 0) begin
          dump_ready = 1'b0;
          if (dump_valid) stall_left--;
        end else begin
          dump_ready = 1'b1;
        end
      end
    endcase
  end

  // Monitor: collect accepted beats, count done pulses, check stall hold.
  logic [4:0]  got_idx_q  [$];
  logic [31:0] got_data_q [$];
  int          done_cnt  = 0;
  int          stall_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [4:0]  prev_idx;
  logic [31:0] prev_data;

  always @(negedge clk) begin
    if (reset_n) begin
      if (done) done_cnt++;
      if (dump_valid && prev_stall) begin
        check_eq("hold_idx", 32'(dump_idx), 32'(prev_idx));
        check_eq("hold_data", dump_data, prev_data);
      end
      if (dump_valid && dump_ready) begin
        got_idx_q.push_back(dump_idx);
        got_data_q.push_back(dump_data);
      end
      if (dump_valid && !dump_ready) stall_cnt++;
      if (override) begin
        check_eq("probe_op", 32'(inst_out[31:26]), 32'h8);
        check_eq("probe_low", 32'(inst_out[20:0]), 32'h0);
      end
      prev_stall = dump_valid && !dump_ready;
      prev_idx   = dump_idx;
      prev_data  = dump_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // One full dump of [f..l] (wrapping), optionally with a stray start mid-dump
  // and/or a start during the DONE cycle, both of which must be ignored.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                          input bit extra, input bit poke_done);
    int n, first_valid, r;
    bit seen_done, poked;
    n = ((int'(l) - int'(f) + NUM_REGS) % NUM_REGS) + 1;
    got_idx_q.delete();
    got_data_q.delete();
    done_cnt   = 0;
    stall_cnt  = 0;
    rdy_mode   = mode;
    stall_left = (mode == 2) ? 10 : 0;
    @(posedge clk); #1;
    first_reg = f; last_reg = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; first_reg = 5'($urandom); last_reg = 5'($urandom);
    first_valid = -1; seen_done = 0; poked = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (dump_valid && first_valid < 0) first_valid = c;
      if (done) begin seen_done = 1; break; end
      @(posedge clk); #1;
      start   = 1'b0;
      inst_in = {6'd0, 26'($urandom)};
      if (extra && c == 6) begin
        start = 1'b1; first_reg = f + 5'd3; last_reg = f;
      end
      if (poke_done && !poked && got_idx_q.size() == n) begin
        start = 1'b1; poked = 1; first_reg = 5'd0; last_reg = 5'd31;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("done_seen", 32'(seen_done), 32'd1);
    check_eq("first_latency", 32'(first_valid), 32'(SETTLE + 1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("done_pulses", 32'(done_cnt), 32'd1);
    check_eq("busy_after", 32'(busy), 32'd0);
    check_eq("override_after", 32'(override), 32'd0);
    check_eq("beats", 32'(got_idx_q.size()), 32'(n));
    for (int k = 0; k < n && k < got_idx_q.size(); k++) begin
      r = (int'(f) + k) % NUM_REGS;
      check_eq("beat_idx", 32'(got_idx_q[k]), 32'(r));
      check_eq("beat_data", got_data_q[k], (r == 0) ? 32'd0 : pattern[r]);
    end
    if (mode == 2) check_eq("stall_cycles", 32'(stall_cnt), 32'd10);
    $display("dump %0d..%0d mode %0d: %0d beats expected, %0d received", f, l, mode, n, got_idx_q.size());
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; first_reg = '0; last_reg = '0;
    inst_in = '0; load = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) pattern[r] = 32'(r * 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_override", 32'(override), 32'd0);
    check_eq("rst_valid", 32'(dump_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_idx", 32'(dump_idx), 32'd0);
    check_eq("rst_data", dump_data, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1; load = 1'b0;

    // Reset in the middle of a dump.
    done_cnt = 0; rdy_mode = 0;
    @(posedge clk); #1;
    first_reg = 5'd0; last_reg = 5'd31; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0; inst_in = 32'h0123_4567;
    @(posedge clk); #1;
    check_eq("midrst_override", 32'(override), 32'd0);
    check_eq("midrst_valid", 32'(dump_valid), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_inst", inst_out, inst_in);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("midrst_no_done", 32'(done_cnt), 32'd0);
    check_eq("midrst_idle", 32'(busy), 32'd0);
    $display("mid-dump reset: busy=%0b done_pulses=%0d", busy, done_cnt);

    run_dump(5'd0, 5'd31, 0, 1'b0, 1'b0);
    run_dump(5'd30, 5'd1, 1, 1'b0, 1'b0);
    run_dump(5'd7, 5'd7, 2, 1'b0, 1'b1);
    run_dump(5'd10, 5'd20, 1, 1'b1, 1'b0);

    // Random register contents and ranges.
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < NUM_REGS; r++) pattern[r] = $urandom;
      @(posedge clk); #1; load = 1'b1;
      @(posedge clk); #1; load = 1'b0;
      run_dump(5'($urandom), 5'($urandom), 1, 1'($urandom), 1'($urandom));
    end

    // Probes must have left the register file untouched.
    for (int r = 1; r < NUM_REGS; r++) check_eq("reg_unchanged", regs[r], pattern[r]);
    // With the sequencer idle the fetch stream passes straight through.
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      inst_in = {6'd0, 26'($urandom)};
      @(negedge clk);
      check_eq("passthru", inst_out, inst_in);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
